// File: rtl/branch_select_pkg.sv
// Shared branch types and the sequence-number age compare.
// Used by the ALUs, the ROB and branch_select.
package branch_select_pkg;

  localparam int SQN_W = 7;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic [31:0] dstPC;
    SqN          sqN;
    logic        taken;
  } BranchProv;

  // a is older than b when the wrapped difference is negative.
  function automatic logic sqn_older(SqN a, SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

endpackage

// File: rtl/branch_age_tree.sv
// Combinational oldest-of-N reduction over branch reports.
// Ties resolve to the lower unit index.
module branch_age_tree
  import branch_select_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic [NUM_UNITS-1:0] IN_valid,
  input  SqN                   IN_sqN [NUM_UNITS],
  output logic                 OUT_valid,
  output logic [IDX_W-1:0]     OUT_idx
);

  localparam int LEAVES = 1 << $clog2(NUM_UNITS);

  logic             nValid [1:2*LEAVES-1];
  logic [IDX_W-1:0] nIdx   [1:2*LEAVES-1];
  SqN               nSqN   [1:2*LEAVES-1];
  logic             pickR;

  // Heap-ordered tree: leaves at LEAVES.., root at node 1.
  always_comb begin
    pickR = 1'b0;
    for (int i = 0; i < LEAVES; i++) begin
      if (i < NUM_UNITS) begin
        nValid[LEAVES+i] = IN_valid[i];
        nSqN[LEAVES+i]   = IN_sqN[i];
      end else begin
        nValid[LEAVES+i] = 1'b0;
        nSqN[LEAVES+i]   = '0;
      end
      nIdx[LEAVES+i] = IDX_W'(i);
    end
    for (int n = LEAVES - 1; n >= 1; n--) begin
      pickR = nValid[2*n+1] &&
              (!nValid[2*n] ||
               sqn_older(nSqN[2*n+1], nSqN[2*n]));
      nValid[n] = nValid[2*n] || nValid[2*n+1];
      nIdx[n]   = pickR ? nIdx[2*n+1] : nIdx[2*n];
      nSqN[n]   = pickR ? nSqN[2*n+1] : nSqN[2*n];
    end
    OUT_valid = nValid[1];
    OUT_idx   = nIdx[1];
  end

endmodule

// File: rtl/branch_select.sv
// Picks the oldest ALU mispredict as the core redirect and
// holds an invalidation window so ALUs drop younger uops.
module branch_select
  import branch_select_pkg::*;
#(
  parameter int NUM_UNITS   = 2,
  parameter int HOLD_CYCLES = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  BranchProv IN_branches [NUM_UNITS],
  input  logic      IN_flush,
  output BranchProv OUT_branch,
  output logic      OUT_invalidate,
  output SqN        OUT_invalidateSqN
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] holdCnt;
  logic [CNT_W-1:0] holdCntNext;
  SqN               curSqN;
  SqN               curSqNNext;

  logic [NUM_UNITS-1:0] cand;
  SqN                   candSqN [NUM_UNITS];
  logic                 winValid;
  logic [IDX_W-1:0]     winIdx;
  BranchProv            winBr;

  // Only reports older than the held one may compete.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      candSqN[i] = IN_branches[i].sqN;
      cand[i] = IN_branches[i].taken && !IN_flush &&
                (state == IDLE ||
                 sqn_older(IN_branches[i].sqN, curSqN));
    end
  end

  branch_age_tree #(
    .NUM_UNITS(NUM_UNITS)
  ) ageTree (
    .IN_valid (cand),
    .IN_sqN   (candSqN),
    .OUT_valid(winValid),
    .OUT_idx  (winIdx)
  );

  assign winBr = IN_branches[winIdx];

  // Window control: open/reload on a winner, count down otherwise.
  always_comb begin
    stateNext   = state;
    holdCntNext = holdCnt;
    curSqNNext  = curSqN;
    unique case (state)
      IDLE: begin
        if (winValid) begin
          stateNext   = HOLD;
          holdCntNext = CNT_W'(HOLD_CYCLES);
          curSqNNext  = winBr.sqN;
        end
      end
      HOLD: begin
        if (winValid) begin
          holdCntNext = CNT_W'(HOLD_CYCLES);
          curSqNNext  = winBr.sqN;
        end else if (holdCnt == CNT_W'(1)) begin
          stateNext   = IDLE;
          holdCntNext = '0;
        end else begin
          holdCntNext = holdCnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext   = IDLE;
        holdCntNext = '0;
      end
    endcase
    if (IN_flush) begin
      stateNext   = IDLE;
      holdCntNext = '0;
    end
  end

  // State, counter and registered redirect output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      holdCnt          <= '0;
      OUT_branch.taken <= 1'b0;
    end else begin
      state   <= stateNext;
      holdCnt <= holdCntNext;
      curSqN  <= curSqNNext;
      if (winValid) begin
        OUT_branch       <= winBr;
        OUT_branch.taken <= 1'b1;
      end else begin
        OUT_branch.taken <= 1'b0;
      end
    end
  end

  assign OUT_invalidate    = (state == HOLD);
  assign OUT_invalidateSqN = curSqN;

endmodule

// File: tb/tb_branch_select.sv
// Scoreboard bench for branch_select: directed plan cases
// followed by random reports, flushes and resets.
module tb_branch_select;
  import branch_select_pkg::*;

  localparam int N = 2;
  localparam int H = 3;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      flush = 1'b0;
  BranchProv br [N];
  BranchProv outBr;
  logic      outInv;
  SqN        outInvSqN;

  branch_select #(
    .NUM_UNITS  (N),
    .HOLD_CYCLES(H)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_branches      (br),
    .IN_flush         (flush),
    .OUT_branch       (outBr),
    .OUT_invalidate   (outInv),
    .OUT_invalidateSqN(outInvSqN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    SqN          sqN;
    logic        inv;
    SqN          invSqN;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: window described by the edge at which it closes.
  int edgeNo = 0;
  int winEnd = -100;
  SqN refSqN = '0;

  function automatic bit refOlder(SqN a, SqN b);
    int d;
    d = (int'(a) - int'(b) + 128) % 128;
    return d >= 64;
  endfunction

  task automatic step(
    input logic r, input logic f,
    input logic t0, input SqN s0, input logic [31:0] p0,
    input logic t1, input SqN s1, input logic [31:0] p1,
    input string tag
  );
    logic        t [N];
    SqN          s [N];
    logic [31:0] p [N];
    exp_t        e;
    bit          act;
    int          best;
    t[0] = t0; s[0] = s0; p[0] = p0;
    t[1] = t1; s[1] = s1; p[1] = p1;
    @(negedge clk);
    rst = r;
    flush = f;
    for (int u = 0; u < N; u++) begin
      br[u].taken = t[u];
      br[u].sqN   = s[u];
      br[u].dstPC = p[u];
    end
    e.taken = 1'b0;
    e.pc = '0;
    e.sqN = '0;
    e.tag = tag;
    act = (edgeNo - 1) < winEnd;
    if (r || f) begin
      winEnd = edgeNo;
    end else begin
      best = -1;
      for (int u = 0; u < N; u++)
        if (t[u] && (!act || refOlder(s[u], refSqN)))
          if (best < 0 || refOlder(s[u], s[best]))
            best = u;
      if (best >= 0) begin
        refSqN  = s[best];
        winEnd  = edgeNo + H;
        e.taken = 1'b1;
        e.pc    = p[best];
        e.sqN   = s[best];
      end
    end
    e.inv    = edgeNo < winEnd;
    e.invSqN = refSqN;
    edgeNo++;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, '0, '0, 0, '0, '0, tag);
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (outBr.taken !== e.taken) begin
          errors++;
          $display("FAIL %s pulse: got %0b want %0b",
                   e.tag, outBr.taken, e.taken);
        end
        if (e.taken) begin
          checks++;
          if (outBr.dstPC !== e.pc || outBr.sqN !== e.sqN) begin
            errors++;
            $display("FAIL %s payload: got pc=%h sqN=%h want pc=%h sqN=%h",
                     e.tag, outBr.dstPC, outBr.sqN, e.pc, e.sqN);
          end
        end
        checks++;
        if (outInv !== e.inv) begin
          errors++;
          $display("FAIL %s invalidate: got %0b want %0b",
                   e.tag, outInv, e.inv);
        end
        if (e.inv) begin
          checks++;
          if (outInvSqN !== e.invSqN) begin
            errors++;
            $display("FAIL %s invSqN: got %h want %h",
                     e.tag, outInvSqN, e.invSqN);
          end
        end
      end
    end
  end

  initial begin
    SqN base;
    for (int u = 0; u < N; u++) br[u] = '0;

    step(1, 0, 0, '0, '0, 0, '0, '0, "reset");
    step(1, 0, 1, 7'd3, 32'h4, 0, '0, '0, "reset");
    idle(1, "reset");

    step(0, 0, 1, 7'd10, 32'h80, 0, '0, '0, "single");
    idle(4, "single_win");

    step(0, 0, 1, 7'd20, 32'h200, 1, 7'd15, 32'h150, "simul");
    step(0, 0, 1, 7'd17, 32'h170, 0, '0, '0, "suppress");
    step(0, 0, 1, 7'd12, 32'h120, 0, '0, '0, "override");
    idle(4, "override_win");

    step(0, 0, 1, 7'h7E, 32'h7E0, 0, '0, '0, "wrap_acc");
    step(0, 0, 0, '0, '0, 1, 7'h02, 32'h20, "wrap_drop");
    step(0, 0, 1, 7'h7C, 32'h7C0, 0, '0, '0, "wrap_old");
    idle(4, "wrap_win");

    step(0, 0, 1, 7'd30, 32'h300, 0, '0, '0, "pre_flush");
    step(0, 1, 1, 7'd5, 32'h50, 0, '0, '0, "flush");
    step(0, 1, 0, '0, '0, 1, 7'd4, 32'h40, "flush_hold");
    step(0, 1, 1, 7'd3, 32'h30, 1, 7'd2, 32'h20, "flush_hold");
    idle(2, "post_flush");

    step(0, 0, 1, 7'd40, 32'h400, 0, '0, '0, "pre_rst");
    step(1, 0, 0, '0, '0, 1, 7'd35, 32'h350, "rst_hold");
    idle(2, "post_rst");

    step(0, 0, 1, 7'd9, 32'h900, 1, 7'd9, 32'h990, "equal");
    step(0, 0, 0, '0, '0, 1, 7'd9, 32'h999, "equal_drop");
    idle(4, "equal_win");

    base = 7'd50;
    for (int i = 0; i < 500; i++) begin
      logic        r, f, t0, t1;
      SqN          s0, s1;
      logic [31:0] p0, p1;
      if ($urandom_range(0, 3) == 0)
        base = SqN'(int'(base) + $urandom_range(0, 6));
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 4);
      t0 = ($urandom_range(0, 99) < 35);
      t1 = ($urandom_range(0, 99) < 35);
      s0 = SqN'(int'(base) + int'($urandom_range(0, 12)) - 6);
      s1 = SqN'(int'(base) + int'($urandom_range(0, 12)) - 6);
      p0 = $urandom;
      p1 = $urandom;
      step(r, f, t0, s0, p0, t1, s1, p1, "random");
    end
    idle(2, "drain");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
